// File: rtl/registersstage1_pkg.sv
// Shared types and constants for pipeline stage 1: opcodes, bus widths, ALU ops, stage states.
package registersstage1_pkg;

  typedef logic [31:0] t_reg;
  typedef logic [4:0]  t_opcode;
  typedef logic [3:0]  t_alu_op;
  typedef logic [1:0]  t_s1_state;

  typedef enum logic [1:0] {
    CW_BYTE = 2'd0,
    CW_WORD = 2'd1,
    CW_LONG = 2'd2
  } t_cycle_width;

  localparam t_opcode OPCODE_NOP   = 5'd0;
  localparam t_opcode OPCODE_LOAD  = 5'd1;
  localparam t_opcode OPCODE_STORE = 5'd2;
  localparam t_opcode OPCODE_LOADI = 5'd3;
  localparam t_opcode OPCODE_ALU   = 5'd4;
  localparam t_opcode OPCODE_ALUM  = 5'd5;
  localparam t_opcode OPCODE_HALT  = 5'd6;

  localparam t_s1_state S1_RUN      = 2'd0;
  localparam t_s1_state S1_BUS_WAIT = 2'd1;
  localparam t_s1_state S1_HALTED   = 2'd2;

  localparam logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0};

  // The reserved width encoding is treated as a full long-word cycle.
  function automatic t_cycle_width decode_width(input logic [1:0] field);
    t_cycle_width width;
    case (field)
      2'd0:    width = CW_BYTE;
      2'd1:    width = CW_WORD;
      default: width = CW_LONG;
    endcase
    return width;
  endfunction

endpackage

// File: rtl/registersstage1_hazard_detect.sv
// Read-after-write interlock: flags an instruction that reads a register stage 2 is about to write.
module registersstage1_hazard_detect
  import registersstage1_pkg::*;
(
  input  t_opcode    opcode,
  input  logic [3:0] index_a,
  input  logic [3:0] index_b,
  input  logic [3:0] write_index,
  input  logic       write_pending,
  output logic       hazard
);

  logic reads_a;
  logic reads_b;

  // Only ports the instruction really consumes count; LOAD's [23:20] is a destination.
  always_comb begin
    reads_a = 1'b0;
    reads_b = 1'b0;
    case (opcode)
      OPCODE_LOAD, OPCODE_ALUM: reads_a = 1'b1;
      OPCODE_STORE, OPCODE_ALU: begin
        reads_a = 1'b1;
        reads_b = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = write_pending &&
                  ((reads_a && (index_a == write_index)) ||
                   (reads_b && (index_b == write_index)));

endmodule

// File: rtl/registersstage1.sv
// Pipeline stage 1: register read, memory bus issue, ALU operand setup, interlock and halt.
module registersstage1
  import registersstage1_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  inbound_instruction,
  output logic [31:0]  outbound_instruction,
  output logic [3:0]   read_index_a,
  output logic [3:0]   read_index_b,
  input  t_reg         read_data_a,
  input  t_reg         read_data_b,
  input  logic [3:0]   stage2_write_index,
  input  logic         stage2_write_pending,
  output logic [31:0]  bus_address,
  output t_cycle_width bus_cycle_width,
  output logic         bus_read,
  output logic         bus_write,
  output t_reg         bus_data_out,
  input  logic         bus_ready,
  output t_alu_op      alu_op,
  output t_reg         alu_operand_a,
  output t_reg         alu_operand_b,
  output logic         stall,
  output logic         halting
);

  t_opcode opcode;
  logic    is_load;
  logic    is_store;
  logic    is_mem;
  logic    hazard;
  t_reg    offset_sext;
  t_reg    alum_imm;
  t_reg    mem_address;
  logic    unused_bit;

  t_s1_state    state_q, state_d;
  logic [31:0]  outbound_q, outbound_d;
  logic [31:0]  held_q, held_d;
  logic         bus_read_q, bus_read_d;
  logic         bus_write_q, bus_write_d;
  logic [31:0]  bus_address_q, bus_address_d;
  t_cycle_width width_q, width_d;
  t_reg         data_q, data_d;
  t_alu_op      alu_op_q, alu_op_d;
  t_reg         alu_a_q, alu_a_d;
  t_reg         alu_b_q, alu_b_d;
  logic         stall_q, stall_d;
  logic         halting_q, halting_d;

  assign opcode     = inbound_instruction[31:27];
  assign is_load    = (opcode == OPCODE_LOAD);
  assign is_store   = (opcode == OPCODE_STORE);
  assign is_mem     = is_load || is_store;
  assign unused_bit = inbound_instruction[24];

  // Memory ops read their store-data register through port B.
  assign read_index_a = inbound_instruction[19:16];
  assign read_index_b = is_mem ? inbound_instruction[23:20] : inbound_instruction[15:12];

  assign offset_sext = {{16{inbound_instruction[15]}}, inbound_instruction[15:0]};
  assign alum_imm    = {{20{inbound_instruction[15]}}, inbound_instruction[15:4]};
  assign mem_address = read_data_a + offset_sext;

  registersstage1_hazard_detect u_hazard_detect (
    .opcode        (opcode),
    .index_a       (read_index_a),
    .index_b       (read_index_b),
    .write_index   (stage2_write_index),
    .write_pending (stage2_write_pending),
    .hazard        (hazard)
  );

  always_comb begin
    state_d       = state_q;
    outbound_d    = NOP_INSTRUCTION;
    held_d        = held_q;
    bus_read_d    = 1'b0;
    bus_write_d   = 1'b0;
    bus_address_d = bus_address_q;
    width_d       = width_q;
    data_d        = data_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    stall_d       = 1'b0;
    halting_d     = halting_q;

    unique case (state_q)
      S1_RUN: begin
        if (hazard) begin
          stall_d = 1'b1;
        end else begin
          outbound_d = inbound_instruction;
          case (opcode)
            OPCODE_LOAD, OPCODE_STORE: begin
              bus_address_d = mem_address;
              width_d       = decode_width(inbound_instruction[26:25]);
              bus_read_d    = is_load;
              bus_write_d   = is_store;
              if (is_store) data_d = read_data_b;
              // Without an immediate ready the instruction waits here until the bus completes.
              if (!bus_ready) begin
                state_d    = S1_BUS_WAIT;
                held_d     = inbound_instruction;
                outbound_d = NOP_INSTRUCTION;
                stall_d    = 1'b1;
              end
            end
            OPCODE_ALU: begin
              alu_op_d = inbound_instruction[3:0];
              alu_a_d  = read_data_a;
              alu_b_d  = read_data_b;
            end
            OPCODE_ALUM: begin
              alu_op_d = inbound_instruction[3:0];
              alu_a_d  = read_data_a;
              alu_b_d  = alum_imm;
            end
            OPCODE_HALT: begin
              state_d   = S1_HALTED;
              halting_d = 1'b1;
              stall_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S1_BUS_WAIT: begin
        bus_read_d  = bus_read_q;
        bus_write_d = bus_write_q;
        stall_d     = 1'b1;
        if (bus_ready) begin
          state_d     = S1_RUN;
          outbound_d  = held_q;
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          stall_d     = 1'b0;
        end
      end
      S1_HALTED: begin
        stall_d = 1'b1;
      end
      default: begin
        state_d = S1_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S1_RUN;
      outbound_q    <= NOP_INSTRUCTION;
      held_q        <= NOP_INSTRUCTION;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_address_q <= '0;
      width_q       <= CW_LONG;
      data_q        <= '0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      stall_q       <= 1'b0;
      halting_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      outbound_q    <= outbound_d;
      held_q        <= held_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      bus_address_q <= bus_address_d;
      width_q       <= width_d;
      data_q        <= data_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      stall_q       <= stall_d;
      halting_q     <= halting_d;
    end
  end

  assign outbound_instruction = outbound_q;
  assign bus_read             = bus_read_q;
  assign bus_write            = bus_write_q;
  assign bus_address          = bus_address_q;
  assign bus_cycle_width      = width_q;
  assign bus_data_out         = data_q;
  assign alu_op               = alu_op_q;
  assign alu_operand_a        = alu_a_q;
  assign alu_operand_b        = alu_b_q;
  assign stall                = stall_q;
  assign halting              = halting_q;

endmodule
